// File: rtl/status_light_ctrl.sv
// Status light sequencer: stretches int_req/wr strobes into held RGB colours,
// prioritises interrupt over write and PWM-dims the registered LED output.
module status_light_ctrl #(
    parameter int unsigned PRESCALE   = 1000,
    parameter int unsigned HOLD_TICKS = 50,
    parameter int unsigned PWM_BITS   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                int_req,
    input  logic                wr,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [2:0]          lights
);

    localparam int unsigned PreW  = $clog2(PRESCALE);
    localparam int unsigned HoldW = $clog2(HOLD_TICKS + 1);

    localparam logic [PreW-1:0]  PreMax     = PreW'(PRESCALE - 1);
    localparam logic [HoldW-1:0] HoldReload = HoldW'(HOLD_TICKS);
    localparam logic [HoldW-1:0] HoldLast   = HoldW'(1);

    localparam logic [2:0] ColReset = 3'b110;
    localparam logic [2:0] ColIdle  = 3'b100;
    localparam logic [2:0] ColInt   = 3'b011;
    localparam logic [2:0] ColWr    = 3'b001;

    typedef enum logic [1:0] {StReset, StIdle, StInt, StWr} state_e;

    state_e              state_q, state_d;
    logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
    logic                wr_pend_q, wr_pend_d;
    logic [PreW-1:0]     pre_cnt_q, pre_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] bright_q, bright_d;
    logic [2:0]          lights_q, lights_d;

    logic       tick;
    logic       expire;
    logic       reload;
    logic       pwm_on;
    logic [2:0] colour;

    // Prescaler: free-running, so hold duration has up to one tick of phase jitter
    assign tick      = (pre_cnt_q == PreMax);
    assign pre_cnt_d = tick ? '0 : pre_cnt_q + PreW'(1);

    // Brightness is only sampled at the period boundary to avoid mid-period glitches
    assign pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    assign bright_d  = (&pwm_cnt_q) ? brightness : bright_q;
    assign pwm_on    = (&bright_q) | (pwm_cnt_q < bright_q);

    assign expire = tick & (hold_cnt_q == HoldLast);

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        wr_pend_d  = wr_pend_q;
        reload     = 1'b0;

        if (int_req) begin
            state_d = StInt;
            reload  = 1'b1;
            if (wr || (state_q == StWr)) begin
                wr_pend_d = 1'b1;
            end
        end else if (wr && (state_q != StInt)) begin
            state_d = StWr;
            reload  = 1'b1;
        end else begin
            if (tick && (hold_cnt_q != HoldLast)) begin
                hold_cnt_d = hold_cnt_q - HoldW'(1);
            end
            // A write during an interrupt is remembered, never reloads the hold
            if (wr) begin
                wr_pend_d = 1'b1;
            end else if (expire) begin
                case (state_q)
                    StInt: begin
                        if (wr_pend_q) begin
                            state_d   = StWr;
                            reload    = 1'b1;
                            wr_pend_d = 1'b0;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                    StWr, StReset: state_d = StIdle;
                    default:       state_d = state_q;
                endcase
            end
        end

        if (reload) begin
            hold_cnt_d = HoldReload;
        end
    end

    always_comb begin
        colour = ColIdle;
        case (state_q)
            StReset: colour = ColReset;
            StIdle:  colour = ColIdle;
            StInt:   colour = ColInt;
            StWr:    colour = ColWr;
            default: colour = ColIdle;
        endcase
    end

    assign lights_d = colour & {3{pwm_on}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StReset;
            hold_cnt_q <= HoldReload;
            wr_pend_q  <= 1'b0;
            pre_cnt_q  <= '0;
            pwm_cnt_q  <= '0;
            bright_q   <= '1;
            lights_q   <= ColReset;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            wr_pend_q  <= wr_pend_d;
            pre_cnt_q  <= pre_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            bright_q   <= bright_d;
            lights_q   <= lights_d;
        end
    end

    assign lights = lights_q;

endmodule

// File: tb/tb_status_light_ctrl.sv
// Bench for status_light_ctrl: directed scenarios plus a randomized run, all
// checked against a cycle-level behavioural model of the indicator.
module tb_status_light_ctrl;

    localparam int PRE  = 4;
    localparam int HOLD = 3;

    localparam int M_RESET = 0;
    localparam int M_IDLE  = 1;
    localparam int M_INT   = 2;
    localparam int M_WR    = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       int_req;
    logic       wr;
    logic [3:0] brightness;
    logic [2:0] lights;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int         m_state, m_hold, m_pre, m_pwm, m_bright;
    bit         m_pend;
    logic [2:0] m_lights;
    logic [3:0] cur_b;

    status_light_ctrl #(
        .PRESCALE  (PRE),
        .HOLD_TICKS(HOLD),
        .PWM_BITS  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .int_req   (int_req),
        .wr        (wr),
        .brightness(brightness),
        .lights    (lights)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] col_of(input int s);
        case (s)
            M_RESET: return 3'b110;
            M_IDLE:  return 3'b100;
            M_INT:   return 3'b011;
            default: return 3'b001;
        endcase
    endfunction

    task automatic model_reset();
        m_state  = M_RESET;
        m_hold   = HOLD;
        m_pend   = 1'b0;
        m_pre    = 0;
        m_pwm    = 0;
        m_bright = 15;
        m_lights = 3'b110;
    endtask

    // One rising edge of the indicator, described by its rules rather than its registers
    task automatic model_edge(input bit ir, input bit w, input logic [3:0] b);
        bit         tk, on, exp_now;
        logic [2:0] nl;
        tk = (m_pre == PRE - 1);
        on = (m_bright == 15) || (m_pwm < m_bright);
        nl = on ? col_of(m_state) : 3'b000;
        if (m_pwm == 15) m_bright = int'(b);
        m_pwm = (m_pwm + 1) % 16;
        m_pre = (m_pre + 1) % PRE;
        if (ir) begin
            if (w || m_state == M_WR) m_pend = 1'b1;
            m_state = M_INT;
            m_hold  = HOLD;
        end else if (w && m_state != M_INT) begin
            m_state = M_WR;
            m_hold  = HOLD;
        end else begin
            exp_now = tk && (m_hold == 1);
            if (tk && m_hold > 1) m_hold = m_hold - 1;
            if (w) begin
                m_pend = 1'b1;
            end else if (exp_now) begin
                if (m_state == M_INT && m_pend) begin
                    m_state = M_WR;
                    m_hold  = HOLD;
                    m_pend  = 1'b0;
                end else if (m_state != M_IDLE) begin
                    m_state = M_IDLE;
                end
            end
        end
        m_lights = nl;
    endtask

    // Starts and ends at a falling edge
    task automatic step(input bit ir, input bit w);
        int_req    = ir;
        wr         = w;
        brightness = cur_b;
        @(posedge clk);
        model_edge(ir, w, cur_b);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Measures how many consecutive observations show col; also tallies model disagreements
    task automatic run_len(input logic [2:0] col, output int n, output int bad);
        n   = 0;
        bad = 0;
        while (lights === col && n < 40) begin
            n++;
            step(1'b0, 1'b0);
            if (lights !== m_lights) bad++;
        end
    endtask

    task automatic test_reset();
        int n, bad;
        n_checks++;
        if (lights !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_value: lights=%b expected=110", lights);
        end
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        n_checks++;
        if (lights !== 3'b001) begin
            n_fail++;
            $display("FAIL pre_reset_wr: lights=%b expected=001", lights);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (lights !== 3'b110) begin
            n_fail++;
            $display("FAIL async_reset: lights=%b expected=110", lights);
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_len(3'b110, n, bad);
        n_checks++;
        if (n != 13 || bad != 0) begin
            n_fail++;
            $display("FAIL reset_hold: len=%0d model_bad=%0d expected len=13 bad=0", n, bad);
        end
        n_checks++;
        if (lights !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_to_idle: lights=%b expected=100", lights);
        end
    endtask

    task automatic test_wr_pulse();
        int n, bad;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        n_checks++;
        if (lights !== 3'b001) begin
            n_fail++;
            $display("FAIL wr_latency: lights=%b expected=001", lights);
        end
        run_len(3'b001, n, bad);
        n_checks++;
        if (n < 9 || n > 12 || bad != 0) begin
            n_fail++;
            $display("FAIL wr_hold: len=%0d model_bad=%0d expected 9..12 bad=0", n, bad);
        end
        n_checks++;
        if (lights !== 3'b100) begin
            n_fail++;
            $display("FAIL wr_to_idle: lights=%b expected=100", lights);
        end
        // Second pulse 5 clocks after the first restarts the hold
        step(1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        run_len(3'b001, n, bad);
        n_checks++;
        if (n < 9 || n > 12 || bad != 0) begin
            n_fail++;
            $display("FAIL wr_extend: len=%0d model_bad=%0d expected 9..12 bad=0", n, bad);
        end
    endtask

    task automatic test_int_hold();
        int n, bad, off;
        step(1'b1, 1'b0);
        off = 0;
        repeat (19) begin
            step(1'b1, 1'b0);
            if (lights !== 3'b011) off++;
        end
        n_checks++;
        if (off != 0) begin
            n_fail++;
            $display("FAIL int_held: non_011_cycles=%0d expected=0", off);
        end
        step(1'b0, 1'b0);
        run_len(3'b011, n, bad);
        n_checks++;
        if (n < 9 || n > 12 || bad != 0) begin
            n_fail++;
            $display("FAIL int_tail: len=%0d model_bad=%0d expected 9..12 bad=0", n, bad);
        end
        n_checks++;
        if (lights !== 3'b100) begin
            n_fail++;
            $display("FAIL int_to_idle: lights=%b expected=100", lights);
        end
    endtask

    task automatic test_wr_then_int();
        int n1, n2, b1, b2;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        n_checks++;
        if (lights !== 3'b001) begin
            n_fail++;
            $display("FAIL wr_before_int: lights=%b expected=001", lights);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        run_len(3'b011, n1, b1);
        run_len(3'b001, n2, b2);
        n_checks++;
        if (n1 < 9 || n1 > 12 || n2 < 9 || n2 > 12 || b1 + b2 != 0) begin
            n_fail++;
            $display("FAIL wr_pend: int_len=%0d wr_len=%0d model_bad=%0d expected 9..12 each",
                     n1, n2, b1 + b2);
        end
        n_checks++;
        if (lights !== 3'b100) begin
            n_fail++;
            $display("FAIL wr_pend_idle: lights=%b expected=100", lights);
        end
    endtask

    task automatic test_simultaneous();
        int n1, n2, b1, b2;
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        n_checks++;
        if (lights !== 3'b011) begin
            n_fail++;
            $display("FAIL simul_int: lights=%b expected=011", lights);
        end
        run_len(3'b011, n1, b1);
        run_len(3'b001, n2, b2);
        n_checks++;
        if (n1 < 9 || n1 > 12 || n2 < 9 || n2 > 12 || b1 + b2 != 0) begin
            n_fail++;
            $display("FAIL simul_seq: int_len=%0d wr_len=%0d model_bad=%0d expected 9..12 each",
                     n1, n2, b1 + b2);
        end
        n_checks++;
        if (lights !== 3'b100) begin
            n_fail++;
            $display("FAIL simul_idle: lights=%b expected=100", lights);
        end
    endtask

    task automatic test_brightness();
        int on_cnt, off_cnt, other, guard;
        cur_b = 4'd4;
        repeat (40) step(1'b0, 1'b0);
        on_cnt = 0; off_cnt = 0; other = 0;
        repeat (16) begin
            step(1'b0, 1'b0);
            if (lights === 3'b100) on_cnt++;
            else if (lights === 3'b000) off_cnt++;
            else other++;
        end
        n_checks++;
        if (on_cnt != 4 || off_cnt != 12 || other != 0) begin
            n_fail++;
            $display("FAIL duty4: on=%0d off=%0d other=%0d expected on=4 off=12 other=0",
                     on_cnt, off_cnt, other);
        end
        cur_b = 4'd0;
        repeat (40) step(1'b0, 1'b0);
        on_cnt = 0;
        repeat (16) begin
            step(1'b0, 1'b0);
            if (lights !== 3'b000) on_cnt++;
        end
        n_checks++;
        if (on_cnt != 0) begin
            n_fail++;
            $display("FAIL duty0: lit_cycles=%0d expected=0", on_cnt);
        end
        // Raise brightness mid-period: old zero duty must persist until the wrap
        guard = 0;
        while (m_pwm != 2 && guard < 40) begin
            step(1'b0, 1'b0);
            guard++;
        end
        cur_b = 4'd15;
        on_cnt = 0;
        repeat (14) begin
            step(1'b0, 1'b0);
            if (lights !== 3'b000) on_cnt++;
        end
        n_checks++;
        if (on_cnt != 0 || guard >= 40) begin
            n_fail++;
            $display("FAIL mid_period: lit_cycles=%0d guard=%0d expected lit=0", on_cnt, guard);
        end
        step(1'b0, 1'b0);
        n_checks++;
        if (lights !== 3'b100) begin
            n_fail++;
            $display("FAIL after_wrap: lights=%b expected=100", lights);
        end
    endtask

    task automatic test_reset_mid_hold();
        int n, bad;
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        do_reset();
        run_len(3'b110, n, bad);
        n_checks++;
        if (n != 13 || bad != 0 || lights !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_mid_hold: len=%0d bad=%0d lights=%b expected len=13 bad=0 100",
                     n, bad, lights);
        end
    endtask

    task automatic test_random();
        bit ir, w;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            if ($urandom_range(0, 49) == 0) cur_b = 4'($urandom_range(0, 15));
            ir = ($urandom_range(0, 14) == 0);
            w  = ($urandom_range(0, 9) == 0);
            step(ir, w);
            n_checks++;
            if (lights !== m_lights) begin
                n_fail++;
                $display("FAIL random[%0d]: lights=%b expected=%b", i, lights, m_lights);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        int_req    = 1'b0;
        wr         = 1'b0;
        cur_b      = 4'd15;
        brightness = 4'd15;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        test_reset();
        test_wr_pulse();
        test_int_hold();
        test_wr_then_int();
        test_simultaneous();
        test_brightness();
        cur_b = 4'd15;
        repeat (20) step(1'b0, 1'b0);
        test_reset_mid_hold();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
